dmem_lsu: RTL and testbench

Parametrised byte-addressable data memory with a valid/ready request channel and a backpressured response channel. It sits between the CPU's MEM stage and on-chip data RAM. It supports RISC-V loads and stores of byte, half and word size with sign or zero extension. Unlike a plain single-cycle memory it adds:
- byte-lane storage;
- error reporting for misaligned, out-of-range and illegal-funct3 accesses;
- a one-entry response buffer;
- a saturating error counter.

---
 rtl/dmem_lsu.sv | 121 ++++++++++++
 tb/tb_dmem_lsu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Byte-lane data memory for the MEM stage with valid/ready request,
// one-entry backpressured response buffer and saturating error count.
module dmem_lsu #(
  parameter int DEPTH_BYTES = 4096,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;

  logic [3:0][7:0] mem [WORDS];

  logic          accept;
  logic          oor;
  logic          bad_f3;
  logic          misal;
  logic          err;
  logic [AW-3:0] widx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [31:0]   ld;
  logic [31:0]   wd;
  logic [3:0]    be;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  assign widx = req_addr[AW-1:2];
  assign lane = req_addr[1:0];
  assign oor  = |req_addr[31:AW];
  assign err  = oor | bad_f3 | misal;

  always_comb begin
    bad_f3 = 1'b0;
    misal  = 1'b0;
    unique case (req_funct3)
      3'b000: misal = 1'b0;
      3'b001: misal = lane[0];
      3'b010: misal = |lane;
      3'b100,
      3'b101: begin
        // unsigned variants exist only for loads
        bad_f3 = req_we;
        misal  = req_funct3[0] & lane[0];
      end
      default: bad_f3 = 1'b1;
    endcase
  end

  assign word = mem[widx];
  assign bsel = 8'(word >> {lane, 3'b000});
  assign hsel = 16'(word >> {lane[1], 4'b0000});

  always_comb begin
    ld = '0;
    unique case (req_funct3)
      3'b000:  ld = {{24{bsel[7]}}, bsel};
      3'b001:  ld = {{16{hsel[15]}}, hsel};
      3'b010:  ld = word;
      3'b100:  ld = {24'b0, bsel};
      3'b101:  ld = {16'b0, hsel};
      default: ld = '0;
    endcase
  end

  always_comb begin
    wd = {4{req_wdata[7:0]}};
    be = 4'b0001 << lane;
    if (req_funct3[1]) begin
      wd = req_wdata;
      be = 4'b1111;
    end else if (req_funct3[0]) begin
      wd = {2{req_wdata[15:0]}};
      be = lane[1] ? 4'b1100 : 4'b0011;
    end
  end

  // storage survives reset
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][i] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err;
      rsp_rdata <= (err || req_we) ? '0 : ld;
      if (err && err_count != '1) begin
        err_count <= err_count + CNT_W'(1);
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu against a byte-array reference model,
// plus directed byte-lane, error, backpressure and saturation cases.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] err_count;

  logic        s_valid;
  logic        s_ready;
  logic        s_we;
  logic [2:0]  s_f3;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_rsp_valid;
  logic        s_rsp_ready;
  logic [31:0] s_rdata;
  logic        s_err;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;
  bit run = 0;

  logic [7:0]  mm [4096];
  logic [15:0] exp_cnt = '0;
  logic [32:0] q [$];

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_BYTES(4096), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_count(err_count)
  );

  dmem_lsu #(.DEPTH_BYTES(4096), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_valid), .req_ready(s_ready),
    .req_we(s_we), .req_funct3(s_f3),
    .req_addr(s_addr), .req_wdata(s_wdata),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_rdata(s_rdata), .rsp_err(s_err),
    .err_count(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: size from funct3, little-endian byte array, plain rules.
  task automatic model(input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wdat,
                       output logic [32:0] r);
    int n;
    bit bad;
    logic [31:0] v;
    logic [31:0] mask;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad = (a >= 32'd4096) || (f3 == 3'd3) || (f3 == 3'd6) ||
          (f3 == 3'd7) || (we && f3[2]);
    if (!bad && (a % n) != 0) bad = 1;
    r = '0;
    if (bad) begin
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      r = {1'b1, 32'b0};
    end else if (we) begin
      for (int i = 0; i < n; i++) mm[a + i] = wdat[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mm[a + i];
      mask = (n == 1) ? 32'hFF : 32'hFFFF;
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
      r = {1'b0, v};
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      logic exp_ready;
      logic [32:0] r;
      exp_ready = (q.size() == 0) || rsp_ready;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
      chk("err_count", 32'(err_count), 32'(exp_cnt));
      if (q.size() != 0) begin
        chk("rsp_rdata", rsp_rdata, q[0][31:0]);
        chk("rsp_err", 32'(rsp_err), 32'(q[0][32]));
        if (rsp_ready) void'(q.pop_front());
      end
      if (req_valid && exp_ready) begin
        model(req_we, req_funct3, req_addr, req_wdata, r);
        q.push_back(r);
      end
    end
  end

  // Called just after a rising edge; leaves just after a rising edge.
  task automatic op(input bit we, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wdat,
                    input logic [31:0] er, input bit ee, input bit do_chk);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wdat;
    req_valid  = 1'b1;
    rsp_ready  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (do_chk) begin
      chk("op_rdata", rsp_rdata, er);
      chk("op_err", 32'(rsp_err), 32'(ee));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    s_valid = 1'b0; s_we = 1'b0; s_f3 = '0;
    s_addr = '0; s_wdata = '0; s_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rdata", rsp_rdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    run = 1;
    @(posedge clk);
    #1;

    op(1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 0, 1);
    op(0, 3'b000, 32'h10, 32'h0, 32'h00000001, 0, 1);
    op(0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFFF, 0, 1);
    op(0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0, 1);
    op(0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 0, 1);
    op(0, 3'b101, 32'h10, 32'h0, 32'h00007F01, 0, 1);
    op(0, 3'b010, 32'h10, 32'h0, 32'h80FF7F01, 0, 1);
    op(1, 3'b000, 32'h11, 32'hAA, 32'h0, 0, 1);
    op(0, 3'b010, 32'h10, 32'h0, 32'h80FFAA01, 0, 1);
    op(1, 3'b001, 32'h12, 32'h1234, 32'h0, 0, 1);
    op(0, 3'b010, 32'h10, 32'h0, 32'h1234AA01, 0, 1);

    op(1, 3'b010, 32'h20, 32'h11111111, 32'h0, 0, 1);
    op(0, 3'b010, 32'h21, 32'h0, 32'h0, 1, 1);
    op(1, 3'b001, 32'h23, 32'hBEEF, 32'h0, 1, 1);
    op(1, 3'b010, 32'h1000, 32'hDEADBEEF, 32'h0, 1, 1);
    op(1, 3'b011, 32'h20, 32'hCAFEF00D, 32'h0, 1, 1);
    op(0, 3'b010, 32'h20, 32'h0, 32'h11111111, 0, 1);
    chk("cnt_after_err", 32'(err_count), 32'd4);

    // stall with a held response and a pending request
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    req_addr = 32'h20;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_hold", rsp_rdata, 32'h1234AA01);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 256; i += 4) begin
      op(1, 3'b010, 32'(i), $urandom, 32'h0, 0, 0);
    end
    op(1, 3'b010, 32'd4092, $urandom, 32'h0, 0, 0);

    repeat (2000) begin
      int r;
      req_valid  = ($urandom_range(9) < 7);
      rsp_ready  = ($urandom_range(9) < 7);
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_wdata  = $urandom;
      r = $urandom_range(19);
      if (r == 0) req_addr = $urandom;
      else if (r == 1) req_addr = 32'(4092 + $urandom_range(8));
      else req_addr = 32'($urandom_range(255));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("drained", 32'(q.size()), 32'd0);
    run = 0;

    s_we = 1'b0; s_f3 = 3'b010; s_addr = 32'h1;
    for (int i = 1; i <= 5; i++) begin
      s_valid = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0;
      @(negedge clk);
      chk("sat_err", 32'(s_err), 32'd1);
      chk("sat_cnt", 32'(s_cnt), 32'((i < 3) ? i : 3));
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
